// File: rtl/memory_pkg.sv
// Shared L1 data-cache types: associativity, way vectors and miss-controller states.
package memory_pkg;

  localparam int DCACHE_L1_ASSOCIATIVITY = 4;

  typedef logic [DCACHE_L1_ASSOCIATIVITY-1:0] repl_vec_t;
  typedef logic [DCACHE_L1_ASSOCIATIVITY-1:0] valid_vec_t;

  typedef enum logic [2:0] {
    DC_IDLE        = 3'd0,
    DC_COMPARE     = 3'd1,
    DC_WRITEBACK   = 3'd2,
    DC_REFILL_REQ  = 3'd3,
    DC_REFILL_WAIT = 3'd4,
    DC_UPDATE      = 3'd5,
    DC_RESPOND     = 3'd6
  } dcache_ctrl_state_t;

endpackage

// File: rtl/d1_miss_ctrl_victim_sel.sv
// d1_victim_sel: round-robin pointer plus invalid-first victim picker; holds the
// chosen victim from the compare cycle until the controller returns to idle.
module d1_victim_sel
  import memory_pkg::*;
#(
  parameter int N_WAY = DCACHE_L1_ASSOCIATIVITY
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             compare_i,
  input  logic             idle_i,
  input  logic             advance_i,
  input  logic [N_WAY-1:0] valid_vec_i,
  output logic [N_WAY-1:0] replace_vec_o
);

  localparam logic [N_WAY-1:0] WAY0 = {{(N_WAY-1){1'b0}}, 1'b1};

  logic [N_WAY-1:0] r_rr;
  logic [N_WAY-1:0] r_victim;
  logic [N_WAY-1:0] w_pick;

  // Descending scan so the lowest-index invalid way wins; RR pointer if all valid.
  always_comb begin
    w_pick = r_rr;
    for (int i = N_WAY - 1; i >= 0; i--) begin
      if (!valid_vec_i[i]) begin
        w_pick = WAY0 << i;
      end else begin
        w_pick = w_pick;
      end
    end
  end

  always_comb begin
    if (compare_i) begin
      replace_vec_o = w_pick;
    end else if (idle_i) begin
      replace_vec_o = r_rr;
    end else begin
      replace_vec_o = r_victim;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr     <= WAY0;
      r_victim <= '0;
    end else begin
      if (compare_i) begin
        r_victim <= w_pick;
      end
      if (advance_i) begin
        r_rr <= {r_rr[N_WAY-2:0], r_rr[N_WAY-1]};
      end
    end
  end

endmodule

// File: rtl/d1_miss_ctrl.sv
// L1 D-cache lookup/miss sequencer: compare, victim writeback, refill, response.
// Optional perf counters enabled by defining D1_MISS_CTRL_PERF_CNT_EN.
module d1_miss_ctrl
  import memory_pkg::*;
#(
  parameter int N_WAY = DCACHE_L1_ASSOCIATIVITY,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  output logic             lookup_en_o,
  input  logic             hit_i,
  input  logic             dirty_i,
  input  logic [N_WAY-1:0] valid_vec_i,
  output logic [N_WAY-1:0] replace_vec_o,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic             refill_valid_o,
  input  logic             refill_ready_i,
  input  logic             refill_resp_valid_i,
  output logic             line_we_o,
  output logic             dirty_set_o,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_hit_o,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic [CNT_W-1:0] wb_cnt_o
);

  dcache_ctrl_state_t r_state;
  dcache_ctrl_state_t w_next;
  logic               r_we;
  logic               r_resp_hit;
  logic               w_idle;
  logic               w_compare;
  logic               w_update;

  assign w_idle    = (r_state == DC_IDLE);
  assign w_compare = (r_state == DC_COMPARE);
  assign w_update  = (r_state == DC_UPDATE);

  // Next-state logic; L2/core inputs outside their own state are ignored.
  always_comb begin
    w_next = r_state;
    case (r_state)
      DC_IDLE:        w_next = req_valid_i ? DC_COMPARE : DC_IDLE;
      DC_COMPARE: begin
        if (hit_i) begin
          w_next = DC_RESPOND;
        end else if (dirty_i) begin
          w_next = DC_WRITEBACK;
        end else begin
          w_next = DC_REFILL_REQ;
        end
      end
      DC_WRITEBACK:   w_next = wb_ready_i ? DC_REFILL_REQ : DC_WRITEBACK;
      DC_REFILL_REQ:  w_next = refill_ready_i ? DC_REFILL_WAIT : DC_REFILL_REQ;
      DC_REFILL_WAIT: w_next = refill_resp_valid_i ? DC_UPDATE : DC_REFILL_WAIT;
      DC_UPDATE:      w_next = DC_RESPOND;
      DC_RESPOND:     w_next = resp_ready_i ? DC_IDLE : DC_RESPOND;
      default:        w_next = DC_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= DC_IDLE;
      r_we       <= 1'b0;
      r_resp_hit <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_idle && req_valid_i) begin
        r_we <= req_we_i;
      end
      if (w_compare) begin
        r_resp_hit <= hit_i;
      end
    end
  end

  assign req_ready_o    = w_idle;
  assign lookup_en_o    = w_idle & req_valid_i;
  assign wb_valid_o     = (r_state == DC_WRITEBACK);
  assign refill_valid_o = (r_state == DC_REFILL_REQ);
  assign line_we_o      = w_update;
  assign dirty_set_o    = r_we & ((w_compare & hit_i) | w_update);
  assign resp_valid_o   = (r_state == DC_RESPOND);
  assign resp_hit_o     = r_resp_hit & resp_valid_o;

  d1_victim_sel #(
    .N_WAY (N_WAY)
  ) u_victim_sel (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .compare_i     (w_compare),
    .idle_i        (w_idle),
    .advance_i     (w_update),
    .valid_vec_i   (valid_vec_i),
    .replace_vec_o (replace_vec_o)
  );

`ifdef D1_MISS_CTRL_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;
  logic [CNT_W-1:0] r_wb_cnt;

  // Free-running counters; natural wrap at 2^CNT_W.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (w_compare && hit_i) begin
        r_hit_cnt <= r_hit_cnt + CNT_ONE;
      end
      if (w_compare && !hit_i) begin
        r_miss_cnt <= r_miss_cnt + CNT_ONE;
      end
      if (wb_valid_o && wb_ready_i) begin
        r_wb_cnt <= r_wb_cnt + CNT_ONE;
      end
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
  assign wb_cnt_o   = r_wb_cnt;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
  assign wb_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_d1_miss_ctrl.sv
// Scoreboard bench for d1_miss_ctrl (N_WAY=4): directed requests push expected
// responses/line updates; a negedge monitor pops and compares them.
module tb_d1_miss_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i, lookup_en_o;
  logic        hit_i, dirty_i;
  logic [3:0]  valid_vec_i, replace_vec_o;
  logic        wb_valid_o, wb_ready_i, refill_valid_o, refill_ready_i;
  logic        refill_resp_valid_i, line_we_o, dirty_set_o;
  logic        resp_valid_o, resp_ready_i, resp_hit_o;
  logic [31:0] hit_cnt_o, miss_cnt_o, wb_cnt_o;

  int n_checks = 0;
  int n_errors = 0;
  int exp_hit  = 0;
  int exp_miss = 0;
  int exp_wb   = 0;

  bit         exp_resp_q[$];
  logic [4:0] exp_upd_q[$];
  logic [4:0] upd_e;
  bit         resp_e;

  always #5 clk_i = ~clk_i;

  d1_miss_ctrl #(.N_WAY(4), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .lookup_en_o(lookup_en_o), .hit_i(hit_i), .dirty_i(dirty_i),
    .valid_vec_i(valid_vec_i), .replace_vec_o(replace_vec_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
    .refill_resp_valid_i(refill_resp_valid_i), .line_we_o(line_we_o),
    .dirty_set_o(dirty_set_o), .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i), .resp_hit_o(resp_hit_o),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .wb_cnt_o(wb_cnt_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_cnt();
`ifdef D1_MISS_CTRL_PERF_CNT_EN
    chk("hit_cnt", hit_cnt_o, 32'(exp_hit));
    chk("miss_cnt", miss_cnt_o, 32'(exp_miss));
    chk("wb_cnt", wb_cnt_o, 32'(exp_wb));
`else
    chk("hit_cnt", hit_cnt_o, 32'd0);
    chk("miss_cnt", miss_cnt_o, 32'd0);
    chk("wb_cnt", wb_cnt_o, 32'd0);
`endif
  endtask

  // Monitor: line writes and response handshakes are matched against the queues.
  always @(negedge clk_i) begin
    if (!rst_i && line_we_o) begin
      if (exp_upd_q.size() == 0) begin
        chk("spurious_line_we", 32'(line_we_o), 32'd0);
      end else begin
        upd_e = exp_upd_q.pop_front();
        chk("upd_victim", 32'(replace_vec_o), 32'(upd_e[3:0]));
        chk("upd_dirty_set", 32'(dirty_set_o), 32'(upd_e[4]));
      end
    end
    if (!rst_i && resp_valid_o && resp_ready_i) begin
      if (exp_resp_q.size() == 0) begin
        chk("spurious_resp", 32'(resp_valid_o), 32'd0);
      end else begin
        resp_e = exp_resp_q.pop_front();
        chk("resp_hit", 32'(resp_hit_o), 32'(resp_e));
      end
    end
  end

  task automatic do_req(input bit we, input bit hit, input bit dirty,
                        input logic [3:0] vv, input logic [3:0] exp_vic,
                        input int wb_dly, input int rf_dly, input int rs_dly);
    req_valid_i = 1'b1;
    req_we_i    = we;
    #1;
    chk("idle_ready", 32'(req_ready_o), 32'd1);
    chk("lookup_en", 32'(lookup_en_o), 32'd1);
    tick();
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    hit_i       = hit;
    dirty_i     = dirty;
    valid_vec_i = vv;
    #1;
    chk("cmp_victim", 32'(replace_vec_o), 32'(exp_vic));
    chk("cmp_dirty_set", 32'(dirty_set_o), 32'(hit & we));
    chk("cmp_line_we", 32'(line_we_o), 32'd0);
    exp_resp_q.push_back(hit);
    if (hit) begin
      exp_hit++;
    end else begin
      exp_miss++;
      exp_upd_q.push_back({we, exp_vic});
    end
    tick();
    hit_i       = 1'b0;
    dirty_i     = 1'b0;
    valid_vec_i = 4'b1111;
    if (!hit) begin
      if (dirty) begin
        exp_wb++;
        for (int k = 0; k <= wb_dly; k++) begin
          chk("wb_valid", 32'(wb_valid_o), 32'd1);
          chk("wb_refill_quiet", 32'(refill_valid_o), 32'd0);
          chk("wb_victim", 32'(replace_vec_o), 32'(exp_vic));
          if (k == wb_dly) wb_ready_i = 1'b1;
          tick();
        end
        wb_ready_i = 1'b0;
      end
      chk("wb_idle", 32'(wb_valid_o), 32'd0);
      chk("refill_valid", 32'(refill_valid_o), 32'd1);
      refill_ready_i = 1'b1;
      tick();
      refill_ready_i = 1'b0;
      for (int k = 0; k <= rf_dly; k++) begin
        chk("rfw_refill_low", 32'(refill_valid_o), 32'd0);
        chk("rfw_line_we_low", 32'(line_we_o), 32'd0);
        chk("rfw_victim", 32'(replace_vec_o), 32'(exp_vic));
        if (k == rf_dly) refill_resp_valid_i = 1'b1;
        tick();
      end
      refill_resp_valid_i = 1'b0;
      chk("upd_line_we", 32'(line_we_o), 32'd1);
      tick();
      chk("upd_line_we_pulse", 32'(line_we_o), 32'd0);
    end else begin
      chk("hit_no_l2", 32'(wb_valid_o | refill_valid_o), 32'd0);
      chk("hit_dirty_set_done", 32'(dirty_set_o), 32'd0);
    end
    for (int k = 0; k <= rs_dly; k++) begin
      chk("resp_valid", 32'(resp_valid_o), 32'd1);
      if (k == rs_dly) resp_ready_i = 1'b1;
      tick();
    end
    resp_ready_i = 1'b0;
    chk("back_idle", 32'(req_ready_o), 32'd1);
    chk("resp_dropped", 32'(resp_valid_o), 32'd0);
    chk_cnt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; hit_i = 1'b0; dirty_i = 1'b0;
    valid_vec_i = 4'b1111; wb_ready_i = 1'b0; refill_ready_i = 1'b0;
    refill_resp_valid_i = 1'b0; resp_ready_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_replace", 32'(replace_vec_o), 32'h1);
    chk("rst_valids", 32'({wb_valid_o, refill_valid_o, resp_valid_o}), 32'd0);
    chk("rst_pulses", 32'({line_we_o, dirty_set_o, resp_hit_o}), 32'd0);
    chk_cnt();

    do_req(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0001, 0, 0, 0);   // load hit
    do_req(1'b1, 1'b1, 1'b0, 4'b1111, 4'b0001, 0, 0, 1);   // store hit, delayed resp_ready
    do_req(1'b0, 1'b0, 1'b0, 4'b1011, 4'b0100, 0, 2, 0);   // invalid-first victim
    chk("rr_after_invalid", 32'(replace_vec_o), 32'h2);
    do_req(1'b1, 1'b0, 1'b1, 4'b1111, 4'b0010, 3, 0, 0);   // dirty store miss, slow wb
    do_req(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0100, 0, 0, 0);
    do_req(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1000, 0, 1, 0);
    do_req(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0001, 0, 0, 0);   // RR wrapped
    chk("rr_after_wrap", 32'(replace_vec_o), 32'h2);

    // Reset while waiting for refill data; a late response must be ignored.
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    tick();
    chk("rst_scn_refill_req", 32'(refill_valid_o), 32'd1);
    refill_ready_i = 1'b1;
    tick();
    refill_ready_i = 1'b0;
    chk("rst_scn_refill_wait", 32'({req_ready_o, refill_valid_o, line_we_o}), 32'd0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
    chk("rst_scn_idle", 32'(req_ready_o), 32'd1);
    chk("rst_scn_rr", 32'(replace_vec_o), 32'h1);
    chk_cnt();
    refill_resp_valid_i = 1'b1;
    tick();
    refill_resp_valid_i = 1'b0;
    chk("late_resp_line_we", 32'(line_we_o), 32'd0);
    chk("late_resp_idle", 32'(req_ready_o), 32'd1);
    chk("late_resp_no_resp", 32'(resp_valid_o), 32'd0);
    do_req(1'b0, 1'b1, 1'b0, 4'b0110, 4'b0001, 0, 0, 0);   // hit after reset

    tick();
    chk("resp_q_drained", 32'(exp_resp_q.size()), 32'd0);
    chk("upd_q_drained", 32'(exp_upd_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
